// File: rtl/ice40_ram_stream_reader_if.sv
// Bundle of every signal the ice40 RAM stream reader exchanges with its
// neighbours: the burst command channel, the SB_RAM40_4K read port, the
// output stream and the status flags. The reader owns the master side.
interface ice40_ram_stream_reader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 12
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [LEN_WIDTH-1:0]  CMD_LEN;
    logic [ADDR_WIDTH-1:0] RADDR;
    logic                  RE;
    logic                  RCLKE;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_LAST;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        input  CMD_VALID, CMD_ADDR, CMD_LEN, RDATA, OUT_READY,
        output CMD_READY, RADDR, RE, RCLKE, OUT_VALID, OUT_DATA, OUT_LAST,
               BUSY, DONE
    );

    modport slave (
        output CMD_VALID, CMD_ADDR, CMD_LEN, RDATA, OUT_READY,
        input  CMD_READY, RADDR, RE, RCLKE, OUT_VALID, OUT_DATA, OUT_LAST,
               BUSY, DONE
    );
endinterface

// File: rtl/ice40_ram_stream_reader.sv
// Burst read controller for an iCE40 SB_RAM40_4K read port. A command
// (start address, word count) is turned into a run of RAM reads; the RAM's
// one-cycle read latency is absorbed by a 2-entry buffer and the words leave
// in address order on a valid/ready stream. Reads are only issued when the
// buffer is guaranteed a free slot for the returning word, so backpressure
// never loses data.
module ice40_ram_stream_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                          CLK,
    input  logic                          ASYNCRESET,
    ice40_ram_stream_reader_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  issue_rem;
    logic [LEN_WIDTH-1:0]  out_rem;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_0;
    logic [DATA_WIDTH-1:0] fifo_1;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;

    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  out_valid;
    logic                  out_last;
    logic [2:0]            credit;

    // Handshake decode and the credit rule: a read may go out only if the
    // buffered words plus the one still in flight, minus the one leaving this
    // cycle, leave room for the new word when it returns.
    always_comb begin
        accept    = 1'b0;
        issue     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        credit    = 3'd0;

        accept    = (state == IDLE) && bus.CMD_VALID;
        out_valid = (occ != 2'd0);
        pop       = out_valid && bus.OUT_READY;
        push      = inflight;
        out_last  = out_valid && (out_rem == LEN_WIDTH'(1));
        credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == RUN) && (issue_rem != '0) && (credit <= 3'd1);
    end

    assign bus.CMD_READY = (state == IDLE);
    assign bus.BUSY      = (state != IDLE);
    assign bus.RCLKE     = (state != IDLE);
    assign bus.DONE      = (state == FLUSH);
    assign bus.RE        = issue;
    assign bus.RADDR     = addr_q;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = rd_ptr ? fifo_1 : fifo_0;
    assign bus.OUT_LAST  = out_last;

    // Burst state machine: latches the command, steps the read address and
    // both remaining-word counters, and tracks the read that is in flight.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= IDLE;
            addr_q    <= '0;
            issue_rem <= '0;
            out_rem   <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q    <= bus.CMD_ADDR;
                        issue_rem <= bus.CMD_LEN;
                        out_rem   <= bus.CMD_LEN;
                        state     <= (bus.CMD_LEN == '0) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        issue_rem <= issue_rem - LEN_WIDTH'(1);
                    end
                    if (pop && (out_rem != '0)) begin
                        out_rem <= out_rem - LEN_WIDTH'(1);
                    end
                    if (pop && out_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer: RDATA is captured only in the cycle after a
    // read was issued, and the head word stays put until the consumer takes it.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            fifo_0 <= '0;
            fifo_1 <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    fifo_1 <= bus.RDATA;
                end else begin
                    fifo_0 <= bus.RDATA;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule
